// File: rtl/im_pkg.sv
// Shared constants and state encoding for the instruction-memory arbiter.
package im_pkg;

    localparam int unsigned IM_AW            = 6;
    localparam int unsigned IM_DW            = 32;
    localparam int unsigned IM_DEPTH         = 64;
    localparam int unsigned IM_HOST_WAIT_MAX = 4;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

endpackage

// File: rtl/im_arbiter.sv
// Shares the instruction-memory port between CPU fetch and host: clears the
// array after reset, then arbitrates fetch/host reads and host program loads.
module im_arbiter
    import im_pkg::*;
#(
    parameter int unsigned AW            = IM_AW,
    parameter int unsigned DW            = IM_DW,
    parameter int unsigned DEPTH         = IM_DEPTH,
    parameter int unsigned HOST_WAIT_MAX = IM_HOST_WAIT_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [DW-1:0] fetch_data,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_valid,
    output logic [DW-1:0] host_rdata,
    input  logic          load_start,
    input  logic          load_end,
    output logic          cpu_stall,
    output logic          cpu_restart,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned    AGW     = $clog2(HOST_WAIT_MAX + 1);
    localparam logic [AGW-1:0] AGE_MAX = AGW'(HOST_WAIT_MAX);
    localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);

    logic [1:0]     state;
    logic [AW-1:0]  cnt;
    logic [AGW-1:0] age;
    logic           load_pend;
    logic           restart_q;
    logic           host_rd;
    logic           host_force;
    logic           clear_done;

    assign cpu_restart = restart_q;

    always_comb begin
        host_rd    = host_req && !host_we;
        host_force = host_rd && (age >= AGE_MAX);
        clear_done = (state == ST_CLEAR) && (cnt == LAST);
        fetch_gnt  = 1'b0;
        host_gnt   = 1'b0;
        cpu_stall  = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = fetch_addr;
        mem_wdata  = '0;
        case (state)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = cnt;
            end
            ST_RUN: begin
                // A starved host read steals the port; the CPU stalls that cycle.
                host_gnt  = host_rd && (!fetch_req || host_force);
                fetch_gnt = fetch_req && !host_gnt;
                cpu_stall = fetch_req && host_gnt;
                if (host_gnt) mem_addr = host_addr;
            end
            ST_LOAD: begin
                host_gnt = host_req;
                mem_addr = host_addr;
                mem_we   = host_req && host_we;
                if (host_req && host_we) mem_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            cnt         <= '0;
            age         <= '0;
            load_pend   <= 1'b0;
            restart_q   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            host_valid  <= 1'b0;
            host_rdata  <= '0;
        end else begin
            fetch_valid <= fetch_gnt;
            if (fetch_gnt) fetch_data <= mem_rdata;
            host_valid <= host_gnt && !host_we;
            if (host_gnt && !host_we) host_rdata <= mem_rdata;
            restart_q <= clear_done || ((state == ST_LOAD) && load_end);

            if ((state != ST_RUN) || host_gnt) age <= '0;
            else if (host_rd && (age < AGE_MAX)) age <= age + 1'b1;

            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (clear_done) begin
                        state     <= (load_pend || load_start) ? ST_LOAD : ST_RUN;
                        load_pend <= 1'b0;
                    end else if (load_start) begin
                        load_pend <= 1'b1;
                    end
                end
                ST_RUN:  if (load_start) state <= ST_LOAD;
                ST_LOAD: if (load_end)   state <= ST_RUN;
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_im_arbiter.sv
// Bench for im_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model with its own memory image.
module tb_im_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int HWM   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_valid;
    logic [DW-1:0] host_rdata;
    logic          load_start;
    logic          load_end;
    logic          cpu_stall;
    logic          cpu_restart;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    im_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .HOST_WAIT_MAX(HWM)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_valid(host_valid),
        .host_rdata(host_rdata), .load_start(load_start), .load_end(load_end),
        .cpu_stall(cpu_stall), .cpu_restart(cpu_restart), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Instruction memory instance the arbiter drives
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    // Reference model: mode 0=clear, 1=run, 2=load
    int            m_mode, m_cnt, m_age;
    bit            m_pend, m_restart, m_fv, m_hv;
    logic [DW-1:0] m_fd, m_hd;
    logic [DW-1:0] rmem [DEPTH];

    bit            e_fg, e_hg, e_stall, e_we, e_hread;
    int            e_addr;
    logic [DW-1:0] e_wdata;

    int vectors = 0;
    int miscompares = 0;
    int obs_we, obs_restart;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_age = 0;
        m_pend = 0; m_restart = 0; m_fv = 0; m_hv = 0;
        m_fd = '0; m_hd = '0;
    endtask

    task automatic predict();
        e_fg = 0; e_hg = 0; e_stall = 1; e_we = 0; e_addr = -1; e_wdata = '0;
        e_hread = host_req && !host_we;
        if (m_mode == 0) begin
            e_we = 1; e_addr = m_cnt;
        end else if (m_mode == 1) begin
            e_hg    = e_hread && (!fetch_req || m_age >= HWM);
            e_fg    = fetch_req && !e_hg;
            e_stall = fetch_req && e_hg;
            if (e_hg) e_addr = int'(host_addr);
            else if (e_fg) e_addr = int'(fetch_addr);
        end else begin
            e_hg = host_req;
            if (host_req) e_addr = int'(host_addr);
            e_we = host_req && host_we;
            if (e_we) e_wdata = host_wdata;
        end
    endtask

    task automatic model_step();
        bit start_now;
        start_now = load_start;
        m_fv = e_fg;
        if (e_fg) m_fd = rmem[fetch_addr];
        m_hv = e_hg && !host_we;
        if (e_hg && !host_we) m_hd = rmem[host_addr];
        if (e_we) rmem[e_addr] = e_wdata;
        m_restart = (m_mode == 0 && m_cnt == DEPTH - 1) || (m_mode == 2 && load_end);
        if (m_mode != 1 || e_hg) m_age = 0;
        else if (e_hread) m_age = m_age + 1;
        case (m_mode)
            0: begin
                if (m_cnt == DEPTH - 1) begin
                    m_mode = (m_pend || start_now) ? 2 : 1;
                    m_pend = 0;
                end else if (start_now) m_pend = 1;
                m_cnt = (m_cnt + 1) % DEPTH;
            end
            1: if (start_now) m_mode = 2;
            default: if (load_end) m_mode = 1;
        endcase
        if (rst) model_reset();
    endtask

    // One clock: compare everything against the model, then advance both
    task automatic cycle();
        #1;
        predict();
        chk1("fetch_gnt", fetch_gnt, e_fg);
        chk1("host_gnt", host_gnt, e_hg);
        chk1("cpu_stall", cpu_stall, e_stall);
        chk1("mem_we", mem_we, e_we);
        if (e_addr >= 0) chk32("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk32("mem_wdata", mem_wdata, e_wdata);
        chk1("cpu_restart", cpu_restart, m_restart);
        chk1("fetch_valid", fetch_valid, m_fv);
        chk32("fetch_data", fetch_data, m_fd);
        chk1("host_valid", host_valid, m_hv);
        chk32("host_rdata", host_rdata, m_hd);
        if (mem_we === 1'b1) obs_we++;
        if (cpu_restart === 1'b1) obs_restart++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 0; fetch_addr = '0; host_req = 0; host_we = 0;
        host_addr = '0; host_wdata = '0; load_start = 0; load_end = 0;
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] d);
        host_req = 1; host_we = 1; host_addr = AW'(a); host_wdata = d;
        cycle();
        host_req = 0; host_we = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        rst = 0;
        obs_we = 0; obs_restart = 0;

        // Clear sweep and first entry into RUN
        for (int i = 0; i < 70; i++) cycle();
        chk32("clear_len", 32'(obs_we), 32'd64);
        chk32("restart_pulses", 32'(obs_restart), 32'd1);
        #1 chk1("run_stall", cpu_stall, 1'b0);

        // Program load, restart, then fetch back
        load_start = 1; cycle(); load_start = 0;
        host_write(5, 32'h20080020);
        host_write(11, 32'h8C150004);
        host_write(3, 32'h13572468);
        load_end = 1; cycle(); load_end = 0;
        chk1("restart_after_load", cpu_restart, 1'b1);
        chk32("mem11_written", mem[11], 32'h8C150004);
        fetch_req = 1; fetch_addr = 6'd11;
        #1 chk1("fetch11_gnt", fetch_gnt, 1'b1);
        cycle();
        fetch_addr = 6'd5;
        chk1("fetch11_valid", fetch_valid, 1'b1);
        chk32("fetch11_data", fetch_data, 32'h8C150004);
        cycle();
        fetch_req = 0;
        chk32("fetch5_data", fetch_data, 32'h20080020);
        cycle();
        chk1("fetch_valid_one_cycle", fetch_valid, 1'b0);

        // Host read starved by continuous fetch
        fetch_req = 1; fetch_addr = 6'd0;
        host_req = 1; host_we = 0; host_addr = 6'd3;
        for (int i = 0; i < 4; i++) begin
            #1 chk1("starve_host_denied", host_gnt, 1'b0);
            cycle();
        end
        #1;
        chk1("forced_host_gnt", host_gnt, 1'b1);
        chk1("forced_fetch_deny", fetch_gnt, 1'b0);
        chk1("forced_stall", cpu_stall, 1'b1);
        cycle();
        host_req = 0;
        chk1("forced_host_valid", host_valid, 1'b1);
        chk32("forced_host_rdata", host_rdata, 32'h13572468);
        fetch_req = 0;
        cycle();

        // Reset in the middle of a load
        load_start = 1; cycle(); load_start = 0;
        for (int i = 0; i < 3; i++) host_write(20 + i, $urandom);
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            #1 chk32("resweep_addr", 32'(mem_addr), 32'(i));
            cycle();
        end
        for (int a = 0; a < DEPTH; a++) begin
            fetch_req = 1; fetch_addr = AW'(a);
            cycle();
            chk32("readback_zero", fetch_data, 32'h0);
        end
        fetch_req = 0;
        cycle();

        // load_start latched during the clear sweep
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < 10; i++) cycle();
        load_start = 1; cycle(); load_start = 0;
        for (int i = 0; i < DEPTH - 11; i++) cycle();
        fetch_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("clear_to_load_stall", cpu_stall, 1'b1);
            chk1("clear_to_load_nofetch", fetch_gnt, 1'b0);
            cycle();
        end
        fetch_req = 0;
        load_end = 1; cycle(); load_end = 0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            fetch_req  = ($urandom % 4) != 0;
            fetch_addr = AW'($urandom);
            host_req   = ($urandom % 3) == 0;
            host_we    = ($urandom % 4) == 0;
            host_addr  = AW'($urandom);
            host_wdata = $urandom;
            load_start = ($urandom % 40) == 0;
            load_end   = ($urandom % 25) == 0;
            rst        = ($urandom % 500) == 0;
            cycle();
        end
        rst = 0;
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/im_arbiter.md
# im_arbiter

Sequencer and arbiter for the 64-word, 32-bit instruction memory. It shares the single memory port between the CPU fetch path and a host/debug port. After reset it zero-clears the array, then runs the CPU. It also supports a host program-load mode that stalls the CPU, accepts writes, and restarts the CPU at PC 0. The block sits between the fetch stage, the host loader, and a write-enabled instruction memory instance with combinational read.

## Interface
Parameters:
- AW, 6, word-address width
- DW, 32, data width
- DEPTH, 64, words in memory; clear sweep covers 0..DEPTH-1
- HOST_WAIT_MAX, 4, consecutive denied host-read cycles in RUN before host is forced a grant

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  CPU fetch request
- fetch_addr  in  AW  fetch word address
- fetch_gnt  out  1  fetch granted this cycle
- fetch_valid  out  1  fetch_data valid (one cycle after grant)
- fetch_data  out  DW  registered fetched instruction
- host_req  in  1  host access request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access granted this cycle
- host_valid  out  1  host_rdata valid (one cycle after read grant)
- host_rdata  out  DW  registered host read data
- load_start  in  1  pulse: enter program-load mode
- load_end  in  1  pulse: leave program-load mode
- cpu_stall  out  1  CPU must hold PC and ignore fetch_data
- cpu_restart  out  1  one-cycle pulse: CPU resets PC to 0
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory combinational read data

## Operation
- States are CLEAR, RUN and LOAD.
- CLEAR (entered on rst):
  - A counter sweeps 0..DEPTH-1.
  - Each cycle drives mem_we=1, mem_addr=counter, mem_wdata=0.
  - cpu_stall=1; fetch_gnt=host_gnt=0.
  - After writing DEPTH-1, go to LOAD if a load_start was latched during CLEAR, else go to RUN.
  - A pulse on cpu_restart marks the exit from CLEAR.
- RUN:
  - Fetch has priority. If fetch_req=1, grant fetch: mem_addr=fetch_addr, mem_we=0.
  - Host reads are granted only when fetch_req=0, or when the age counter reaches HOST_WAIT_MAX. On a forced grant, the fetch is denied and cpu_stall=1 for that cycle.
  - The age counter increments each cycle a host read is pending and denied. It resets to 0 on any host grant.
  - Host writes are never granted in RUN; host_gnt stays 0 while host_we=1.
  - load_start goes to LOAD next cycle.
- LOAD:
  - cpu_stall=1; fetch_gnt=0.
  - Every host_req is granted the same cycle. A write drives mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata. A read returns data as in RUN.
  - load_end goes to RUN next cycle, with cpu_restart=1 in that first RUN cycle.
- Simultaneous events:
  - load_start and load_end in the same cycle: in RUN, load_start wins; in LOAD, load_end wins.
  - load_end in RUN or CLEAR is ignored.
  - load_start in LOAD is ignored.
- Every granted read captures mem_rdata into fetch_data or host_rdata at the grant edge. At most one grant occurs per cycle.
- Address is exactly AW bits; no wrap logic is needed beyond the counter terminal value DEPTH-1.

## Timing
- Reset values:
  - state=CLEAR, counter=0, age=0.
  - cpu_stall=1.
  - fetch_gnt, fetch_valid, host_gnt, host_valid, cpu_restart = 0.
  - fetch_data, host_rdata = 0.
  - mem_we=1, mem_addr=0, mem_wdata=0, starting the clear sweep in the first post-reset cycle.
- Grants are combinational from current state and requests.
- Read latency is 1 cycle: the valid pulse and data appear the cycle after the grant and last exactly one cycle.
- Writes take effect at the grant edge.
- CLEAR lasts exactly DEPTH cycles after rst deasserts.
- rst asserted in any state, including mid-load or mid-clear, returns to CLEAR next edge and restarts the sweep at 0. Valid outputs and any pending load_start are dropped.

## Structure
- Shared package im_pkg holds the state encoding (CLEAR/RUN/LOAD), the AW, DW and DEPTH constants, and the HOST_WAIT_MAX default.
- Single module; the sweep counter and age counter are inline.
- The memory is an external write-enabled instruction memory instance, not part of this block.

## Test plan
- rst for 2 cycles, then release:
  - mem_we=1 for exactly 64 cycles with addresses 0..63 and wdata 0.
  - cpu_stall=1 throughout; cpu_restart pulses once; then RUN with cpu_stall=0.
- RUN, fetch_req=1 at addr 5 with mem holding 0x20080020 at 5 → fetch_gnt=1; next cycle fetch_valid=1 and fetch_data=0x20080020.
- RUN, fetch_req held 1 and host read of addr 3 pending:
  - host is denied for 4 cycles.
  - On the 5th cycle host_gnt=1, fetch_gnt=0, cpu_stall=1.
  - host_valid follows one cycle later.
- load_start, then host writes 0x8C150004 to addr 11, then load_end:
  - cpu_stall=1 throughout LOAD; the write lands at addr 11.
  - cpu_restart pulses in the first RUN cycle.
  - A subsequent fetch of addr 11 returns 0x8C150004.
- rst asserted mid-LOAD after 3 writes → next cycle CLEAR restarts at addr 0 and all 64 words read back 0 afterward.
- load_start pulsed during CLEAR → after the sweep, the FSM enters LOAD, not RUN, and cpu_stall stays 1.
